dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 25 ++
 rtl/dmem_arbiter.sv | 97 +++++++++
 tb/tb_dmem_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared state encoding, default widths and tie-break helper for dmem_arbiter
package dmem_arbiter_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_C = 2'd1,
        GNT_L = 2'd2
    } state_e;

    // prefer_l only matters when both ports are requesting.
    function automatic state_e arb_pick(input logic req_c, input logic req_l, input logic prefer_l);
        if (req_c && req_l) begin
            return prefer_l ? GNT_L : GNT_C;
        end else if (req_c) begin
            return GNT_C;
        end else if (req_l) begin
            return GNT_L;
        end
        return IDLE;
    endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester (core / loader) arbiter onto a single-port data memory
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_c,
    input  logic              we_c,
    input  logic [ADDR_W-1:0] addr_c,
    input  logic [DATA_W-1:0] wdata_c,
    input  logic              req_l,
    input  logic              we_l,
    input  logic [ADDR_W-1:0] addr_l,
    input  logic [DATA_W-1:0] wdata_l,
    output logic              gnt_c,
    output logic              gnt_l,
    output logic              rvalid_c,
    output logic              rvalid_l,
    output logic [DATA_W-1:0] rdata,
    output logic              stall_c,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e state_q, state_d;
    logic   last_l_q, last_l_d;
    logic   rd_pend_c_q, rd_pend_c_d;
    logic   rd_pend_l_q, rd_pend_l_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_l_q    <= 1'b0;
            rd_pend_c_q <= 1'b0;
            rd_pend_l_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_l_q    <= last_l_d;
            rd_pend_c_q <= rd_pend_c_d;
            rd_pend_l_q <= rd_pend_l_d;
        end
    end

    // A GNT state only issues if its requester is still asserting; a requester that
    // kept req high through its grant cycle is taken as presenting a new transaction,
    // which is what allows back-to-back grants without an IDLE bubble.
    always_comb begin
        state_d   = state_q;
        last_l_d  = last_l_q;
        gnt_c     = 1'b0;
        gnt_l     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = addr_c;
        mem_wdata = wdata_c;
        case (state_q)
            IDLE: begin
                // Out of IDLE (including the first decision after reset) the core wins a tie.
                state_d = arb_pick(req_c, req_l, 1'b0);
            end
            GNT_C: begin
                gnt_c    = req_c;
                mem_en   = req_c;
                mem_we   = req_c & we_c;
                last_l_d = 1'b0;
                state_d  = arb_pick(req_c, req_l, ~last_l_d);
            end
            GNT_L: begin
                gnt_l     = req_l;
                mem_en    = req_l;
                mem_we    = req_l & we_l;
                mem_addr  = addr_l;
                mem_wdata = wdata_l;
                last_l_d  = 1'b1;
                state_d   = arb_pick(req_c, req_l, ~last_l_d);
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rd_pend_c_d = gnt_c & ~we_c;
    assign rd_pend_l_d = gnt_l & ~we_l;

    assign rvalid_c = rd_pend_c_q;
    assign rvalid_l = rd_pend_l_q;
    assign rdata    = mem_rdata;
    assign stall_c  = req_c & ~gnt_c;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_c, we_c, req_l, we_l;
    logic [31:0] addr_c, wdata_c, addr_l, wdata_l;
    logic        gnt_c, gnt_l, rvalid_c, rvalid_l, stall_c;
    logic [31:0] rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_c(req_c), .we_c(we_c), .addr_c(addr_c), .wdata_c(wdata_c),
        .req_l(req_l), .we_l(we_l), .addr_l(addr_l), .wdata_l(wdata_l),
        .gnt_c(gnt_c), .gnt_l(gnt_l), .rvalid_c(rvalid_c), .rvalid_l(rvalid_l),
        .rdata(rdata), .stall_c(stall_c),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: unwritten words return a fixed per-address pattern.
    logic [31:0] mem [0:63];
    bit          wr_vld [0:63];

    function automatic logic [31:0] init_val(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h1111_1111;
            32'h4:   return 32'h2222_2222;
            32'h10:  return 32'hDEAD_BEEF;
            default: return 32'hC0DE_0000 + {26'd0, a[7:2]};
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr[7:2]]    <= mem_wdata;
                wr_vld[mem_addr[7:2]] <= 1'b1;
            end else begin
                mem_rdata <= wr_vld[mem_addr[7:2]] ? mem[mem_addr[7:2]] : init_val(mem_addr);
            end
        end
    end

    typedef struct packed {logic l; logic we; logic [31:0] a; logic [31:0] d;} gnt_t;
    typedef struct packed {logic l; logic [31:0] d;} rd_t;
    gnt_t exp_g[$];
    rd_t  exp_r[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic eg(input logic l, input logic we, input logic [31:0] a, input logic [31:0] d);
        exp_g.push_back('{l, we, a, d});
    endtask

    task automatic er(input logic l, input logic [31:0] d);
        exp_r.push_back('{l, d});
    endtask

    // Monitor: grants and read returns are popped from the scoreboard as they appear.
    bit pend_c = 0, pend_l = 0;
    always @(negedge clk) begin
        gnt_t e;
        rd_t  r;
        bit   npc, npl;
        npc = 0;
        npl = 0;
        if (rst) begin
            pend_c = 0;
            pend_l = 0;
            check("rst_outs", {gnt_c, gnt_l, rvalid_c, rvalid_l, mem_en, mem_we}, 0);
        end
        check("gnt_onehot", gnt_c & gnt_l, 0);
        check("rvalid_onehot", rvalid_c & rvalid_l, 0);
        check("stall_c", stall_c, req_c & ~gnt_c);
        check("rvalid_c_timing", rvalid_c, pend_c);
        check("rvalid_l_timing", rvalid_l, pend_l);
        if (rvalid_c | rvalid_l) begin
            if (exp_r.size() == 0) begin
                check("unexpected_rvalid", rvalid_c | rvalid_l, 0);
            end else begin
                r = exp_r.pop_front();
                check("rvalid_port", {rvalid_l, rvalid_c}, {r.l, ~r.l});
                check("rdata", rdata, r.d);
            end
        end
        if (gnt_c | gnt_l | mem_en) begin
            if (exp_g.size() == 0) begin
                check("unexpected_grant", gnt_c | gnt_l | mem_en, 0);
            end else begin
                e = exp_g.pop_front();
                check("gnt_port", {gnt_l, gnt_c}, {e.l, ~e.l});
                check("mem_en", mem_en, 1);
                check("mem_we", mem_we, e.we);
                check("mem_addr", mem_addr, e.a);
                if (e.we) check("mem_wdata", mem_wdata, e.d);
                npc = ~e.l & ~e.we;
                npl = e.l & ~e.we;
            end
        end else begin
            check("idle_mem", {mem_en, mem_we}, 0);
        end
        pend_c = npc;
        pend_l = npl;
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds the request until granted, then returns one cycle later with req still high.
    task automatic txn(input bit is_l, input logic we, input logic [31:0] a, input logic [31:0] d,
                       output int waited);
        bit got;
        got    = 0;
        waited = 0;
        if (is_l) begin
            req_l = 1; we_l = we; addr_l = a; wdata_l = d;
        end else begin
            req_c = 1; we_c = we; addr_c = a; wdata_c = d;
        end
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (is_l ? gnt_l : gnt_c) got = 1;
            else waited++;
        end
        if (!got) check("txn_timeout", is_l ? gnt_l : gnt_c, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1;
        cycles(2);
        rst = 0;
        cycles(1);
    endtask

    int w1, w2, w3, w4;

    initial begin
        rst = 1;
        req_c = 0; we_c = 0; addr_c = '0; wdata_c = '0;
        req_l = 0; we_l = 0; addr_l = '0; wdata_l = '0;
        cycles(2);
        req_c = 1;
        cycles(1);
        req_c = 0;
        rst = 0;
        cycles(2);

        // Core-only read
        eg(0, 0, 32'h10, 0);
        er(0, 32'hDEAD_BEEF);
        txn(0, 0, 32'h10, 0, w1);
        req_c = 0;
        check("core_read_wait", w1, 1);
        cycles(3);

        // Simultaneous requests after reset: C, L, C, L
        reset_pulse();
        eg(0, 0, 32'h0, 0);  eg(1, 0, 32'h30, 0);
        eg(0, 0, 32'h4, 0);  eg(1, 0, 32'h34, 0);
        er(0, 32'h1111_1111); er(1, 32'hC0DE_000C);
        er(0, 32'h2222_2222); er(1, 32'hC0DE_000D);
        fork
            begin txn(0, 0, 32'h0, 0, w1); txn(0, 0, 32'h4, 0, w2); req_c = 0; end
            begin txn(1, 0, 32'h30, 0, w3); txn(1, 0, 32'h34, 0, w4); req_l = 0; end
        join
        check("tie_c1_wait", w1, 1);
        check("tie_l1_wait", w3, 2);
        check("tie_c2_wait", w2, 1);
        check("tie_l2_wait", w4, 1);
        cycles(3);

        // Loader write then core read of the same word
        eg(1, 1, 32'h20, 32'h55);
        eg(0, 0, 32'h20, 0);
        er(0, 32'h55);
        txn(1, 1, 32'h20, 32'h55, w1);
        req_l = 0;
        txn(0, 0, 32'h20, 0, w2);
        req_c = 0;
        check("lw_wait", w1, 1);
        check("cr_after_lw_wait", w2, 1);
        cycles(3);

        // Back-to-back core reads
        eg(0, 0, 32'h0, 0); eg(0, 0, 32'h4, 0);
        er(0, 32'h1111_1111); er(0, 32'h2222_2222);
        txn(0, 0, 32'h0, 0, w1);
        txn(0, 0, 32'h4, 0, w2);
        req_c = 0;
        check("b2b_first_wait", w1, 1);
        check("b2b_second_wait", w2, 0);
        cycles(3);

        // Reset in the cycle after a loader read grant: no rvalid_l afterwards
        eg(1, 0, 32'h30, 0);
        txn(1, 0, 32'h30, 0, w1);
        rst = 1;
        req_l = 0;
        cycles(2);
        rst = 0;
        cycles(2);

        // Continuous loader writes with one core read
        for (int i = 0; i < 3; i++) eg(1, 1, 32'h40 + 32'(4 * i), 32'h100 + 32'(i));
        eg(0, 0, 32'h10, 0);
        for (int i = 3; i < 6; i++) eg(1, 1, 32'h40 + 32'(4 * i), 32'h100 + 32'(i));
        er(0, 32'hDEAD_BEEF);
        fork
            begin
                for (int i = 0; i < 6; i++) txn(1, 1, 32'h40 + 32'(4 * i), 32'h100 + 32'(i), w3);
                req_l = 0;
            end
            begin
                cycles(3);
                txn(0, 0, 32'h10, 0, w1);
                req_c = 0;
            end
        join
        check("starve_core_wait", w1, 1);
        cycles(4);

        check("grants_drained", exp_g.size(), 0);
        check("reads_drained", exp_r.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
